// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light controller and its phase monitor.
// Phase encodings, per-road lamp decode values and the ERR bit positions.
package traffic_pkg;

    typedef enum logic [2:0] {
        UNSYNC  = 3'd0,
        NS_GO   = 3'd1,
        NS_WARN = 3'd2,
        RED_A   = 3'd3,
        EW_GO   = 3'd4,
        EW_WARN = 3'd5,
        RED_B   = 3'd6
    } phase_t;

    typedef enum logic [1:0] {
        OFF_BAD = 2'd0,
        G       = 2'd1,
        Y       = 2'd2,
        R       = 2'd3
    } lamp_t;

    localparam int unsigned ERR_ENC      = 0;
    localparam int unsigned ERR_CONFLICT = 1;
    localparam int unsigned ERR_SEQ      = 2;
    localparam int unsigned ERR_TIMING   = 3;
    localparam int unsigned ERR_W        = 4;

    // Successor of each state on the legal ring; UNSYNC has no successor.
    function automatic phase_t next_legal(input phase_t p);
        case (p)
            NS_GO:   return NS_WARN;
            NS_WARN: return RED_A;
            RED_A:   return EW_GO;
            EW_GO:   return EW_WARN;
            EW_WARN: return RED_B;
            RED_B:   return NS_GO;
            default: return UNSYNC;
        endcase
    endfunction

endpackage

// File: rtl/tl_lamp_decode.sv
// Decodes one road's three lamp lines into a single lamp value.
// Only a one-hot pattern is valid; everything else reports OFF_BAD.
module tl_lamp_decode
    import traffic_pkg::*;
(
    input  logic       g,
    input  logic       y,
    input  logic       r,
    output logic [1:0] lamp,
    output logic       valid
);

    always_comb begin
        lamp  = OFF_BAD;
        valid = 1'b0;
        case ({g, y, r})
            3'b100: begin lamp = G; valid = 1'b1; end
            3'b010: begin lamp = Y; valid = 1'b1; end
            3'b001: begin lamp = R; valid = 1'b1; end
            default: begin lamp = OFF_BAD; valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/tl_phase_monitor.sv
// Passive traffic-light phase checker: registers the six lamps, decodes them,
// tracks the legal phase ring and flags encoding/conflict/sequence/timing faults.
module tl_phase_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned GRN_MIN = 4,
    parameter int unsigned YEL_MIN = 2,
    parameter int unsigned RED_MIN = 1
)(
    input  logic             CK,
    input  logic             RST,
    input  logic             NS_G,
    input  logic             NS_Y,
    input  logic             NS_R,
    input  logic             EW_G,
    input  logic             EW_Y,
    input  logic             EW_R,
    output logic [2:0]       PHASE,
    output logic [CNT_W-1:0] DWELL,
    output logic             PHASE_CHG,
    output logic [3:0]       ERR,
    output logic [3:0]       ERR_STK
);

    logic [2:0] ns_q;
    logic [2:0] ew_q;
    logic       in_vld;

    // in_vld keeps the cleared input register from being decoded as an ENC fault.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            ns_q   <= '0;
            ew_q   <= '0;
            in_vld <= 1'b0;
        end else begin
            ns_q   <= {NS_G, NS_Y, NS_R};
            ew_q   <= {EW_G, EW_Y, EW_R};
            in_vld <= 1'b1;
        end
    end

    logic [1:0] ns_lamp;
    logic [1:0] ew_lamp;
    logic       ns_ok;
    logic       ew_ok;

    tl_lamp_decode u_ns_dec (
        .g     (ns_q[2]),
        .y     (ns_q[1]),
        .r     (ns_q[0]),
        .lamp  (ns_lamp),
        .valid (ns_ok)
    );

    tl_lamp_decode u_ew_dec (
        .g     (ew_q[2]),
        .y     (ew_q[1]),
        .r     (ew_q[0]),
        .lamp  (ew_lamp),
        .valid (ew_ok)
    );

    phase_t           state;
    logic [CNT_W-1:0] dwell;
    logic             chg;
    logic [ERR_W-1:0] err;
    logic [ERR_W-1:0] err_stk;

    function automatic logic [CNT_W-1:0] min_dwell(input phase_t p);
        case (p)
            NS_GO, EW_GO:     return CNT_W'(GRN_MIN);
            NS_WARN, EW_WARN: return CNT_W'(YEL_MIN);
            default:          return CNT_W'(RED_MIN);
        endcase
    endfunction

    logic   enc;
    logic   conflict;
    logic   obs_red;
    phase_t obs;
    phase_t tgt;

    always_comb begin
        enc      = in_vld && !(ns_ok && ew_ok);
        conflict = in_vld && ns_ok && ew_ok && (ns_lamp != R) && (ew_lamp != R);
        obs_red  = 1'b0;
        obs      = UNSYNC;
        if (ns_lamp == R && ew_lamp == R) begin
            obs_red = 1'b1;
        end else if (ew_lamp == R) begin
            obs = (ns_lamp == G) ? NS_GO : NS_WARN;
        end else if (ns_lamp == R) begin
            obs = (ew_lamp == G) ? EW_GO : EW_WARN;
        end
        // All-red is ambiguous on the lamps; the side it follows picks RED_A or RED_B.
        tgt = obs;
        if (obs_red) begin
            tgt = (state == NS_GO || state == NS_WARN || state == RED_A) ? RED_A : RED_B;
        end
    end

    phase_t           state_nxt;
    logic [CNT_W-1:0] dwell_nxt;
    logic             chg_nxt;
    logic [ERR_W-1:0] err_nxt;

    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell;
        chg_nxt   = 1'b0;
        err_nxt   = '0;
        if (!in_vld) begin
            state_nxt = state;
        end else if (enc) begin
            err_nxt[ERR_ENC] = 1'b1;
        end else if (conflict) begin
            err_nxt[ERR_CONFLICT] = 1'b1;
        end else if (state == UNSYNC) begin
            state_nxt = tgt;
            dwell_nxt = CNT_W'(1);
        end else if (tgt == state) begin
            if (dwell != '1) begin
                dwell_nxt = dwell + CNT_W'(1);
            end
        end else begin
            state_nxt = tgt;
            dwell_nxt = CNT_W'(1);
            chg_nxt   = 1'b1;
            if (tgt == next_legal(state)) begin
                err_nxt[ERR_TIMING] = (dwell < min_dwell(state));
            end else begin
                err_nxt[ERR_SEQ] = 1'b1;
            end
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state   <= UNSYNC;
            dwell   <= '0;
            chg     <= 1'b0;
            err     <= '0;
            err_stk <= '0;
        end else begin
            state   <= state_nxt;
            dwell   <= dwell_nxt;
            chg     <= chg_nxt;
            err     <= err_nxt;
            err_stk <= err_stk | err_nxt;
        end
    end

    assign PHASE     = state;
    assign DWELL     = dwell;
    assign PHASE_CHG = chg;
    assign ERR       = err;
    assign ERR_STK   = err_stk;

endmodule

// File: tb/tb_tl_phase_monitor.sv
// Scoreboard bench for tl_phase_monitor: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them two cycles later.
module tb_tl_phase_monitor;
    import traffic_pkg::*;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DMAX  = 15;
    localparam logic [2:0] LG   = 3'b100;
    localparam logic [2:0] LY   = 3'b010;
    localparam logic [2:0] LR   = 3'b001;
    localparam logic [2:0] LOFF = 3'b000;

    logic             CK = 1'b0;
    logic             RST = 1'b1;
    logic             NS_G, NS_Y, NS_R, EW_G, EW_Y, EW_R;
    logic [2:0]       PHASE;
    logic [CNT_W-1:0] DWELL;
    logic             PHASE_CHG;
    logic [3:0]       ERR;
    logic [3:0]       ERR_STK;

    tl_phase_monitor #(.CNT_W(CNT_W), .GRN_MIN(4), .YEL_MIN(2), .RED_MIN(1)) dut (
        .CK        (CK),
        .RST       (RST),
        .NS_G      (NS_G),
        .NS_Y      (NS_Y),
        .NS_R      (NS_R),
        .EW_G      (EW_G),
        .EW_Y      (EW_Y),
        .EW_R      (EW_R),
        .PHASE     (PHASE),
        .DWELL     (DWELL),
        .PHASE_CHG (PHASE_CHG),
        .ERR       (ERR),
        .ERR_STK   (ERR_STK)
    );

    always #5 CK = ~CK;

    typedef struct {
        int unsigned due;
        int unsigned phase;
        int unsigned dwell;
        int unsigned chg;
        int unsigned err;
        int unsigned stk;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc    = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    always @(posedge CK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".phase"}, 32'(PHASE), 0);
        chk({tag, ".dwell"}, 32'(DWELL), 0);
        chk({tag, ".chg"},   32'(PHASE_CHG), 0);
        chk({tag, ".err"},   32'(ERR), 0);
        chk({tag, ".stk"},   32'(ERR_STK), 0);
    endtask

    // Called at a negedge: drives lamps now, result is due after the second posedge.
    task automatic step(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                        input int unsigned ph, input int unsigned dw, input int unsigned cg,
                        input int unsigned er, input int unsigned stk);
        exp_t e;
        {NS_G, NS_Y, NS_R} = ns;
        {EW_G, EW_Y, EW_R} = ew;
        e.due   = cyc + 2;
        e.phase = ph;
        e.dwell = dw;
        e.chg   = cg;
        e.err   = er;
        e.stk   = stk;
        e.tag   = tag;
        sb.push_back(e);
        @(negedge CK);
    endtask

    task automatic hold(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                        input int unsigned ph, input int unsigned n, input int unsigned d0,
                        input int unsigned chg0, input int unsigned err0, input int unsigned stk);
        int unsigned d;
        for (int unsigned k = 0; k < n; k++) begin
            d = d0 + k;
            if (d > DMAX) d = DMAX;
            step(tag, ns, ew, ph, d, (k == 0) ? chg0 : 0, (k == 0) ? err0 : 0, stk);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge CK);
        chk("drain.pending", 32'(sb.size()), 0);
    endtask

    always @(negedge CK) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            chk({mon_e.tag, ".phase"}, 32'(PHASE),     mon_e.phase);
            chk({mon_e.tag, ".dwell"}, 32'(DWELL),     mon_e.dwell);
            chk({mon_e.tag, ".chg"},   32'(PHASE_CHG), mon_e.chg);
            chk({mon_e.tag, ".err"},   32'(ERR),       mon_e.err);
            chk({mon_e.tag, ".stk"},   32'(ERR_STK),   mon_e.stk);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        {NS_G, NS_Y, NS_R} = LR;
        {EW_G, EW_Y, EW_R} = LR;
        RST = 1'b1;
        repeat (3) @(negedge CK);
        check_zero("reset");
        RST = 1'b0;

        // Legal ring, then NS_GO held only 3 cycles
        hold("t1.ns_go",   LG, LR, 1, 5, 1, 0, 0, 0);
        hold("t1.ns_warn", LY, LR, 2, 2, 1, 1, 0, 0);
        hold("t1.red_a",   LR, LR, 3, 1, 1, 1, 0, 0);
        hold("t1.ew_go",   LR, LG, 4, 5, 1, 1, 0, 0);
        hold("t1.ew_warn", LR, LY, 5, 2, 1, 1, 0, 0);
        hold("t1.red_b",   LR, LR, 6, 1, 1, 1, 0, 0);
        hold("t2.ns_go",   LG, LR, 1, 3, 1, 1, 0, 0);
        hold("t2.ns_warn", LY, LR, 2, 2, 1, 1, 4'b1000, 4'b1000);
        hold("t2.red_a",   LR, LR, 3, 1, 1, 1, 0, 4'b1000);
        hold("t3.ew_go",   LR, LG, 4, 3, 1, 1, 0, 4'b1000);

        // Conflict freezes state and dwell
        step("t3.conflict", LG, LG, 4, 3, 0, 4'b0010, 4'b1010);
        step("t3.conflict", LG, LG, 4, 3, 0, 4'b0010, 4'b1010);
        hold("t3.resume",   LR, LG, 4, 1, 4, 0, 0, 4'b1010);

        // Dark NS lamps for one cycle
        step("t4.enc",      LOFF, LG, 4, 4, 0, 4'b0001, 4'b1011);
        hold("t4.resume",   LR, LG, 4, 1, 5, 0, 0, 4'b1011);
        hold("t4.ew_warn",  LR, LY, 5, 2, 1, 1, 0, 4'b1011);
        hold("t4.red_b",    LR, LR, 6, 1, 1, 1, 0, 4'b1011);
        hold("t4.ns_go",    LG, LR, 1, 2, 1, 1, 0, 4'b1011);

        // Sequence jumps, all-red resync to either side, short yellow
        hold("t5.jump_ew_go", LR, LG, 4, 1, 1, 1, 4'b0100, 4'b1111);
        hold("t5.red_b_seq",  LR, LR, 6, 1, 1, 1, 4'b0100, 4'b1111);
        hold("t5.warn_seq",   LY, LR, 2, 1, 1, 1, 4'b0100, 4'b1111);
        hold("t5.short_yel",  LR, LR, 3, 1, 1, 1, 4'b1000, 4'b1111);
        hold("t5.ns_go_seq",  LG, LR, 1, 1, 1, 1, 4'b0100, 4'b1111);

        // RED_A entered by resync, then 20 more cycles to saturate DWELL
        hold("t6.red_sat",    LR, LR, 3, 21, 1, 1, 4'b0100, 4'b1111);
        drain();

        @(posedge CK);
        #2 RST = 1'b1;
        #1 check_zero("t6.rst_async");
        repeat (2) @(negedge CK);
        RST = 1'b0;
        hold("t6.resync_red", LR, LR, 6, 2, 1, 0, 0, 0);
        hold("t6.resync_go",  LG, LR, 1, 1, 1, 1, 0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
